player_motion_ctrl: RTL
=======================

// Module: player_motion_ctrl
// PURPOSE
// - Per-player motion controller: clamps mouse X to the player's half-court
//   and runs a fixed-point ballistic jump (launch velocity, constant gravity).
// - Sits between the mouse/UART position source and the blob renderer.
// - One instance per player; side, limits and jump physics are set by parameters.
// - Adds click edge detection, a selectable air-steer mode and a ground-landing clamp.
// PARAMETERS
// - X_MIN      0    left X limit, px (inclusive)
// - X_MAX      500  right X limit, px (inclusive)
// - GROUND_Y   679  resting Y, px (screen Y grows downward)
// - FRAC_BITS  4    fractional bits of internal Y and velocity
// - V0         256  launch velocity, px/tick * 2^FRAC_BITS (256 = 16.0 px/tick)
// - GRAVITY    16   velocity decrement per tick, same scale (16 = 1.0)
// - AIR_STEER  1    1: X follows input while airborne; 0: X frozen at take-off value
// PORTS
// - clk_div      in   1   motion tick clock (~100 Hz)
// - rst          in   1   synchronous, active-high reset
// - xpos_in      in   12  raw mouse X, unsigned px
// - click        in   1   jump request, level (mouse button)
// - xpos_out     out  12  clamped player X
// - ypos_out     out  12  player Y, integer px = y_int >> FRAC_BITS
// - airborne     out  1   1 while in RISE or FALL
// - land_pulse   out  1   one-tick pulse on the tick Y returns to GROUND_Y
// BEHAVIOUR
// - All state is updated on posedge clk_div. rst is sampled on clk_div only.
// - Reset values: xpos_out=X_MIN, ypos_out=GROUND_Y, airborne=0, land_pulse=0,
//   state=GROUND, vy=0, click_d=0.
// - X clamp, 1-tick latency: out = X_MIN if in<X_MIN; X_MAX if in>X_MAX; else in.
//   Limits are inclusive. If AIR_STEER=0 and airborne, xpos_out holds its value.
// - Click edge: jump_req = click & ~click_d. A held click never re-triggers.
// - Internal state: y_int (12+FRAC_BITS bits, unsigned);
//   vy (signed, 13+FRAC_BITS bits, positive = upward).
// - State GROUND: y_int=GROUND_Y<<FRAC_BITS. On jump_req go to RISE with vy=V0.
// - RISE/FALL, every tick:
//   - y_n = y_int - vy (signed arithmetic); vy <= vy - GRAVITY.
//   - The state is RISE while the updated vy > 0, else FALL.
// - Landing: in FALL, if y_n >= GROUND_Y<<FRAC_BITS:
//   - y_int is clamped to GROUND_Y<<FRAC_BITS and vy=0;
//   - state goes to LAND and land_pulse=1 on that tick.
// - LAND: lasts 1 tick, with airborne=0. Then GROUND.
//   A jump_req seen in LAND is ignored.
// - A jump_req while in RISE/FALL is ignored (single jump only).
// - Top clamp: if y_n < 0, y_int=0 and vy=0; the block enters FALL. Y never wraps.
// - rst asserted mid-jump: on the next clk_div edge the block is back in GROUND
//   at GROUND_Y, and no land_pulse is issued.
// - ypos_out = y_int[FRAC_BITS+:12], registered together with the state. A value
//   computed on tick n appears on ypos_out on the same edge that updates y_int.
// - With the defaults: apex Y=543 after 16 ticks. Landing at Y=679 on tick 33
//   after launch, and land_pulse is high on that tick.
// TESTING
// - Reset: assert rst 2 ticks -> xpos_out=0, ypos_out=679, airborne=0, land_pulse=0.
// - Clamp: xpos_in=700 -> xpos_out=500 next tick; xpos_in=250 -> 250.
//   xpos_in=500 -> 500 (inclusive).
// - Full jump (defaults): click 0->1 at tick 0.
//   - ypos_out: 663 at tick 1, 543 at ticks 16-17, 679 at tick 33.
//   - land_pulse=1 only at tick 33. airborne=1 for ticks 1-32.
// - Held click: hold click=1 for 80 ticks -> exactly one jump.
//   Ground Y stays 679 after tick 33.
// - AIR_STEER=0: sweep xpos_in 100->400 mid-jump -> xpos_out stays 100 until LAND.
//   It follows the input from the LAND tick onward.
// - Reset mid-air: assert rst at tick 10 of a jump -> next tick ypos_out=679,
//   airborne=0, no land_pulse.
//   A new click after release jumps normally.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// ---------------------------------------------------------------------------
// player_motion_ctrl
//
// Per-player motion controller. Clamps the raw mouse X into this player's
// half-court and runs a fixed-point ballistic jump (launch velocity, constant
// gravity). Sits between the mouse/UART position source and the blob
// renderer; one instance per player.
//
// Ports
//   clk_div     in   1   motion tick clock (~100 Hz)
//   rst         in   1   synchronous, active-high reset
//   xpos_in     in   12  raw mouse X, unsigned px
//   click       in   1   jump request, level (mouse button)
//   xpos_out    out  12  clamped player X (1-tick latency)
//   ypos_out    out  12  player Y in integer px (screen Y grows downward)
//   airborne    out  1   high while rising or falling
//   land_pulse  out  1   one-tick pulse on the tick Y returns to the ground
//
// State table
//   state      | meaning
//   ST_GROUND  | resting at GROUND_Y, waiting for a click edge
//   ST_RISE    | airborne, vertical velocity still upward (vy > 0)
//   ST_FALL    | airborne, vertical velocity zero or downward
//   ST_LAND    | single tick after touchdown, land_pulse high
// ---------------------------------------------------------------------------
module player_motion_ctrl #(
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 500,
    parameter int GROUND_Y  = 679,
    parameter int FRAC_BITS = 4,
    parameter int V0        = 256,
    parameter int GRAVITY   = 16,
    parameter int AIR_STEER = 1
) (
    input  logic        clk_div,
    input  logic        rst,
    input  logic [11:0] xpos_in,
    input  logic        click,
    output logic [11:0] xpos_out,
    output logic [11:0] ypos_out,
    output logic        airborne,
    output logic        land_pulse
);

    localparam int YW = 12 + FRAC_BITS;   // unsigned fixed-point Y
    localparam int VW = 13 + FRAC_BITS;   // signed fixed-point velocity

    localparam logic [YW-1:0]        Y_GROUND = YW'(GROUND_Y * (2 ** FRAC_BITS));
    localparam logic signed [VW-1:0] V_LAUNCH = VW'(V0);
    localparam logic signed [VW-1:0] V_GRAV   = VW'(GRAVITY);
    localparam logic [11:0]          X_LO     = 12'(X_MIN);
    localparam logic [11:0]          X_HI     = 12'(X_MAX);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2,
        ST_LAND   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [YW-1:0]          y_q, y_d;
    logic signed [VW-1:0]   vy_q, vy_d;
    logic                   click_d;
    logic [11:0]            x_q, x_d;

    logic                   jump_req;
    logic signed [VW-1:0]   vy_n;
    logic signed [YW+1:0]   y_n;
    logic signed [YW+1:0]   y_ground_s;
    logic [11:0]            x_clamp;
    logic                   air_now;
    logic                   air_next;
    logic                   x_freeze;

    // Rising edge of the button only; a held button never re-arms a jump.
    assign jump_req = click & ~click_d;

    // Y step in signed arithmetic two bits wider than y_int so that both an
    // overshoot above the top of the screen (negative) and a landing
    // overshoot are visible before clamping.
    assign y_n        = $signed({2'b00, y_q}) - $signed({vy_q[VW-1], vy_q});
    assign vy_n       = vy_q - V_GRAV;
    assign y_ground_s = $signed({2'b00, Y_GROUND});

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vy_d    = vy_q;
        case (state_q)
            ST_GROUND: begin
                y_d  = Y_GROUND;
                vy_d = '0;
                if (jump_req) begin
                    state_d = ST_RISE;
                    vy_d    = V_LAUNCH;
                end
            end
            ST_RISE, ST_FALL: begin
                if (y_n < 0) begin
                    // Hit the top of the screen: stop dead and start falling.
                    y_d     = '0;
                    vy_d    = '0;
                    state_d = ST_FALL;
                end else if ((state_q == ST_FALL) && (y_n >= y_ground_s)) begin
                    y_d     = Y_GROUND;
                    vy_d    = '0;
                    state_d = ST_LAND;
                end else begin
                    y_d     = y_n[YW-1:0];
                    vy_d    = vy_n;
                    state_d = (vy_n > 0) ? ST_RISE : ST_FALL;
                end
            end
            ST_LAND: begin
                y_d     = Y_GROUND;
                vy_d    = '0;
                state_d = ST_GROUND;
            end
            default: begin
                y_d     = Y_GROUND;
                vy_d    = '0;
                state_d = ST_GROUND;
            end
        endcase
    end

    always_comb begin
        x_clamp = xpos_in;
        if (xpos_in < X_LO) begin
            x_clamp = X_LO;
        end else if (xpos_in > X_HI) begin
            x_clamp = X_HI;
        end
    end

    // Without air steer X is held only while the player is airborne both
    // before and after this edge: the take-off edge still captures the input
    // (take-off value) and the touchdown edge already follows it again.
    assign air_now  = (state_q == ST_RISE) || (state_q == ST_FALL);
    assign air_next = (state_d == ST_RISE) || (state_d == ST_FALL);
    assign x_freeze = (AIR_STEER == 0) && air_now && air_next;

    always_comb begin
        x_d = x_clamp;
        if (x_freeze) begin
            x_d = x_q;
        end
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state_q <= ST_GROUND;
            y_q     <= Y_GROUND;
            vy_q    <= '0;
            click_d <= 1'b0;
            x_q     <= X_LO;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            click_d <= click;
            x_q     <= x_d;
        end
    end

    // All outputs are straight decodes of registers updated on the same edge.
    assign xpos_out   = x_q;
    assign ypos_out   = y_q[FRAC_BITS +: 12];
    assign airborne   = air_now;
    assign land_pulse = (state_q == ST_LAND);

endmodule
